serial_rx: RTL and testbench
============================

# serial_rx

Serial receiver for the 8-bit asynchronous link driven by the b13-style transmitter. It is the other end of the link: it recovers start bit, eight data bits MSB-first and stop bit from an idle-high line. It presents each received byte on a valid/ack handshake and flags framing errors and overruns. It sits between the line input pin and the consumer that previously sourced `data_in` to the transmitter.

## Interface
- `DELAY_TIME`, default 104: bit cell length parameter. Bit period P = DELAY_TIME+2 clocks, the same spacing the transmitter uses.
- `clock` input, 1 bit: single clock; all state changes on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `rx_in` input, 1 bit: serial line, idle high.
- `rx_en` input, 1 bit: receiver enable.
- `rd_ack` input, 1 bit: consumer acknowledges `dato`.
- `dato` output, 8 bits: last received byte.
- `dato_valid` output, 1 bit: `dato` holds an unacknowledged byte.
- `frame_err` output, 1 bit: sticky; last frame had a stop bit of 0.
- `overrun` output, 1 bit: sticky; a byte was dropped because `dato_valid` was still set.
- `busy` output, 1 bit: high in every state except R_IDLE.

## Operation
- Synchronizer: `rx_in` passes through 2 flops (`rx_s1`, `rx_s2`), which reset to 1. Define `rx_prev` as `rx_s2` delayed one cycle, also reset to 1. All decisions use `rx_s2`.
- Counter `rx_conta` is 10 bits. Bit counter `bit_cnt` is 3 bits. Shift register `shreg` is 8 bits; each sample shifts in as `shreg <= {shreg[6:0], rx_s2}`, so the first data bit lands in `dato[7]`.
- Constants: HALF = (DELAY_TIME+2)/2 − 1, integer divide. LAST = DELAY_TIME+1.
- R_IDLE
  - Condition: `rx_en`=1, `rx_prev`=1 and `rx_s2`=0.
  - Action: `rx_conta`<=0, go to R_START.
- R_START
  - `rx_conta` increments each cycle.
  - When `rx_conta`==HALF and `rx_s2`=0: start is confirmed. Set `rx_conta`<=0, `bit_cnt`<=0, `frame_err`<=0, go to R_DATA.
  - When `rx_conta`==HALF and `rx_s2`=1: false start. Go to R_IDLE with no flag change.
- R_DATA
  - `rx_conta` increments.
  - When `rx_conta`==LAST: shift in `rx_s2`, set `rx_conta`<=0, increment `bit_cnt`.
  - After the 8th sample (`bit_cnt` was 7), go to R_STOP.
- R_STOP: when `rx_conta`==LAST, sample the stop bit and go to R_IDLE. Then:
  - Stop bit 1 and (`dato_valid`=0 or `rd_ack`=1): `dato`<=`shreg`, `dato_valid`<=1.
  - Stop bit 1, `dato_valid`=1 and `rd_ack`=0: the byte is dropped, `dato` is unchanged, `overrun`<=1.
  - Stop bit 0: `frame_err`<=1, byte discarded, `dato` and `dato_valid` unchanged except for the normal ack rule.
- Handshake
  - `rd_ack`=1 while `dato_valid`=1 clears `dato_valid` and `overrun` next cycle, unless a delivery happens in the same cycle.
  - When ack and delivery coincide, the delivery wins: `dato_valid` stays 1 and `overrun` is cleared.
  - `rd_ack` while `dato_valid`=0 is ignored.
- `rx_en`=0 in any non-idle state aborts the frame: go to R_IDLE next cycle, `shreg` is discarded and flags are unchanged.
- Asynchronous `reset`, including mid-frame:
  - state R_IDLE;
  - `rx_conta`=0, `bit_cnt`=0, `shreg`=0;
  - `dato`=0, `dato_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0;
  - sync flops = 1.
- `rx_conta` never exceeds LAST; no wrap-around occurs for any DELAY_TIME ≤ 1021.

## Timing
- Falling edge on `rx_in` at cycle c: `rx_s2` goes low at c+2, R_START is entered at c+3, `busy`=1 from c+3.
- Start confirm at c+3+HALF. Data bit k (k=0..7) is sampled at c+3+HALF+(k+1)·P. Stop bit is sampled at c+3+HALF+9·P.
- `dato`/`dato_valid` and `frame_err` become visible the cycle after the stop sample, and `busy` returns to 0 in that same cycle.
- Back-to-back frames are accepted; a new start is detected as soon as R_IDLE sees a high-to-low transition of `rx_s2`.

## Test plan
- DELAY_TIME=4 (P=6, HALF=2). Send 0xA5: start, MSB first, stop=1, 6 cycles per bit -> `dato`=0xA5, `dato_valid`=1 at c+3+2+54+1 = c+60, `frame_err`=0.
- Glitch low for 2 cycles, then high -> start rejected, `busy` drops, `dato_valid` stays 0.
- Send 0x3C with stop=0 -> `frame_err`=1, `dato_valid`=0. Next good frame 0x81 -> `frame_err` cleared at start confirm, `dato`=0x81.
- Send 0x11 without ack, then 0x22 -> `dato`=0x11, `overrun`=1. Pulse `rd_ack` -> `dato_valid`=0 and `overrun`=0 next cycle.
- Pulse `rd_ack` in the exact cycle of the 0x55 stop sample -> `dato`=0x55, `dato_valid`=1, `overrun`=0.
- Assert `reset` during bit 3 of a frame; release, then send 0xF0 -> all outputs 0 during reset, then `dato`=0xF0 is received cleanly.

Source files
------------

// File: rtl/serial_rx.sv
// Asynchronous 8-bit serial receiver (start, 8 data bits MSB-first, stop).
// Delivers bytes on a valid/ack handshake and reports framing errors and overruns.
module serial_rx #(
  parameter int DELAY_TIME = 104
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       rx_en,
  input  logic       rd_ack,
  output logic [7:0] dato,
  output logic       dato_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int HALF = (DELAY_TIME + 2) / 2 - 1;
  localparam int LAST = DELAY_TIME + 1;
  localparam logic [9:0] C_HALF = 10'(HALF);
  localparam logic [9:0] C_LAST = 10'(LAST);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} state_t;

  state_t     r_state, w_next;
  logic       r_rx_s1, r_rx_s2, r_rx_prev;
  logic [9:0] r_conta;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shreg;
  logic [7:0] r_dato;
  logic       r_dato_valid, r_frame_err, r_overrun;
  logic       w_half, w_last, w_deliver, w_drop, w_ferr, w_confirm, w_abort;

  assign w_half  = (r_conta == C_HALF);
  assign w_last  = (r_conta == C_LAST);
  assign w_abort = (r_state != R_IDLE) && !rx_en;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_deliver = 1'b0;
    w_drop    = 1'b0;
    w_ferr    = 1'b0;
    w_confirm = 1'b0;
    case (r_state)
      R_IDLE:
        if (rx_en && r_rx_prev && !r_rx_s2) w_next = R_START;
      R_START:
        if (!rx_en) w_next = R_IDLE;
        else if (w_half) begin
          w_next    = r_rx_s2 ? R_IDLE : R_DATA;
          w_confirm = !r_rx_s2;
        end
      R_DATA:
        if (!rx_en) w_next = R_IDLE;
        else if (w_last && r_bit_cnt == 3'd7) w_next = R_STOP;
      R_STOP:
        if (!rx_en) w_next = R_IDLE;
        else if (w_last) begin
          w_next = R_IDLE;
          // A full holding register only accepts the new byte if it is being acked now
          if (r_rx_s2) begin
            w_deliver = !r_dato_valid || rd_ack;
            w_drop    = r_dato_valid && !rd_ack;
          end else begin
            w_ferr = 1'b1;
          end
        end
      default: w_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rx_s1      <= 1'b1;
      r_rx_s2      <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_conta      <= '0;
      r_bit_cnt    <= '0;
      r_shreg      <= '0;
      r_dato       <= '0;
      r_dato_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_rx_s1   <= rx_in;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;

      if (w_abort) begin
        r_conta <= '0;
        r_shreg <= '0;
      end else begin
        case (r_state)
          R_IDLE:  r_conta <= '0;
          R_START:
            if (w_confirm) begin
              r_conta   <= '0;
              r_bit_cnt <= '0;
            end else begin
              r_conta <= r_conta + 10'd1;
            end
          R_DATA:
            if (w_last) begin
              r_shreg   <= {r_shreg[6:0], r_rx_s2};
              r_conta   <= '0;
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end else begin
              r_conta <= r_conta + 10'd1;
            end
          R_STOP:  r_conta <= w_last ? '0 : r_conta + 10'd1;
          default: r_conta <= '0;
        endcase
      end

      if (w_deliver) begin
        r_dato       <= r_shreg;
        r_dato_valid <= 1'b1;
        r_overrun    <= 1'b0;
      end else begin
        if (rd_ack && r_dato_valid) begin
          r_dato_valid <= 1'b0;
          r_overrun    <= 1'b0;
        end
        if (w_drop) r_overrun <= 1'b1;
      end

      if (w_confirm)   r_frame_err <= 1'b0;
      else if (w_ferr) r_frame_err <= 1'b1;
    end
  end

  assign dato       = r_dato;
  assign dato_valid = r_dato_valid;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != R_IDLE);
endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard bench for serial_rx at DELAY_TIME=4 (6 clocks per bit).
// Stimulus pushes expected deliveries; a negedge monitor pops and compares them.
module tb_serial_rx;
  localparam int DT = 4;

  logic       clock = 1'b0;
  logic       reset, rx_in, rx_en, rd_ack;
  logic [7:0] dato;
  logic       dato_valid, frame_err, overrun, busy;

  serial_rx #(.DELAY_TIME(DT)) dut (
    .clock(clock), .reset(reset), .rx_in(rx_in), .rx_en(rx_en), .rd_ack(rd_ack),
    .dato(dato), .dato_valid(dato_valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         errors = 0;
  int         checks = 0;
  logic       dv_d = 1'b0;
  logic [7:0] dato_d = 8'h00;
  logic       b3, f6, d59;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // A delivery is a rising dato_valid or a new byte replacing a held one
  always @(negedge clock) begin
    if (!reset && dato_valid && (!dv_d || dato !== dato_d)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery: got %0h expected none", dato);
      end else begin
        mon_e = sb.pop_front();
        chk("dlv_dato", 32'(dato), 32'(mon_e.data));
        chk("dlv_frame_err", 32'(frame_err), 32'(mon_e.fe));
        chk("dlv_overrun", 32'(overrun), 32'(mon_e.ov));
      end
    end
    dv_d   <= dato_valid;
    dato_d <= dato;
  end

  // Drives one frame starting in the current cycle (cycle c); i indexes cycle c+i
  task automatic send(input logic [7:0] d, input logic stopb, input logic ack_stop,
                      input int ncyc, output logic busy3, output logic fe6, output logic dv59);
    logic [9:0] fr;
    fr    = {1'b0, d, stopb};
    busy3 = 1'b0;
    fe6   = 1'b0;
    dv59  = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      rx_in  = fr[9 - i / 6];
      rd_ack = ack_stop && (i == 59);
      if (i == 3)  busy3 = busy;
      if (i == 6)  fe6   = frame_err;
      if (i == 59) dv59  = dato_valid;
      @(posedge clock); #1;
    end
    rx_in  = 1'b1;
    rd_ack = 1'b0;
  endtask

  task automatic ack_pulse();
    rd_ack = 1'b1;
    @(posedge clock); #1;
    rd_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rx_in = 1'b1; rx_en = 1'b1; rd_ack = 1'b0;
    idle(3);
    chk("rst_dato", 32'(dato), 32'h0);
    chk("rst_valid", 32'(dato_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    idle(4);

    // Good frame with exact latency: valid low in c+59, high in c+60
    sb.push_back('{data: 8'hA5, fe: 1'b0, ov: 1'b0});
    send(8'hA5, 1'b1, 1'b0, 60, b3, f6, d59);
    chk("a5_busy_c3", 32'(b3), 32'h1);
    chk("a5_valid_c59", 32'(d59), 32'h0);
    chk("a5_valid_c60", 32'(dato_valid), 32'h1);
    chk("a5_busy_c60", 32'(busy), 32'h0);
    ack_pulse();
    chk("a5_ack_valid", 32'(dato_valid), 32'h0);
    idle(3);

    // Two-cycle glitch: start rejected at the half-bit check
    rx_in = 1'b0;
    idle(2);
    rx_in = 1'b1;
    idle(2);
    chk("glitch_busy_mid", 32'(busy), 32'h1);
    idle(4);
    chk("glitch_busy_end", 32'(busy), 32'h0);
    chk("glitch_valid", 32'(dato_valid), 32'h0);

    // Bad stop bit, then a good frame clears frame_err at start confirm
    send(8'h3C, 1'b0, 1'b0, 60, b3, f6, d59);
    chk("3c_frame_err", 32'(frame_err), 32'h1);
    chk("3c_valid", 32'(dato_valid), 32'h0);
    idle(3);
    sb.push_back('{data: 8'h81, fe: 1'b0, ov: 1'b0});
    send(8'h81, 1'b1, 1'b0, 60, b3, f6, d59);
    chk("81_fe_after_confirm", 32'(f6), 32'h0);
    ack_pulse();
    idle(2);

    // Overrun: second byte dropped, ack clears valid and overrun
    sb.push_back('{data: 8'h11, fe: 1'b0, ov: 1'b0});
    send(8'h11, 1'b1, 1'b0, 60, b3, f6, d59);
    send(8'h22, 1'b1, 1'b0, 60, b3, f6, d59);
    chk("ovr_dato", 32'(dato), 32'h11);
    chk("ovr_flag", 32'(overrun), 32'h1);
    chk("ovr_valid", 32'(dato_valid), 32'h1);
    ack_pulse();
    chk("ovr_ack_valid", 32'(dato_valid), 32'h0);
    chk("ovr_ack_flag", 32'(overrun), 32'h0);
    idle(2);

    // Ack coinciding with delivery: delivery wins, overrun cleared
    sb.push_back('{data: 8'h66, fe: 1'b0, ov: 1'b0});
    send(8'h66, 1'b1, 1'b0, 60, b3, f6, d59);
    send(8'h77, 1'b1, 1'b0, 60, b3, f6, d59);
    chk("pre55_overrun", 32'(overrun), 32'h1);
    sb.push_back('{data: 8'h55, fe: 1'b0, ov: 1'b0});
    send(8'h55, 1'b1, 1'b1, 60, b3, f6, d59);
    chk("55_dato", 32'(dato), 32'h55);
    chk("55_valid", 32'(dato_valid), 32'h1);
    chk("55_overrun", 32'(overrun), 32'h0);
    ack_pulse();
    idle(2);

    // Reset during data bit 3, then a clean frame
    send(8'hF0, 1'b1, 1'b0, 27, b3, f6, d59);
    reset = 1'b1;
    #1;
    chk("mrst_dato", 32'(dato), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_flags", 32'({dato_valid, frame_err, overrun}), 32'h0);
    idle(2);
    reset = 1'b0;
    idle(5);
    sb.push_back('{data: 8'hF0, fe: 1'b0, ov: 1'b0});
    send(8'hF0, 1'b1, 1'b0, 60, b3, f6, d59);
    chk("f0_dato", 32'(dato), 32'hF0);
    idle(3);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
